// File: rtl/bram_rr_port_arbiter.sv
// -----------------------------------------------------------------------------
// bram_rr_port_arbiter
//
// Shares one port of the 8192x2 dual-port BRAM wrapper among NREQ requesters
// using a round-robin arbiter. Each requester has a valid/ready request
// channel and gets a one-cycle read-response strobe one clock after its read
// is granted. The arbiter drives the BRAM port pins combinationally.
//
// Optional feature (macro BRAM_ARB_CLEAR_ON_RESET_EN): after reset, a clear
// sweep writes zero to every address (one per cycle) before any request is
// accepted; BUSY is high during the sweep. Without the macro the block starts
// arbitrating straight out of reset and BUSY is tied low.
//
// Ports:
//   clk        in   clock shared with the BRAM
//   rstn       in   asynchronous active-low reset
//   req_valid  in   [NREQ]     per-requester request valid
//   req_ready  out  [NREQ]     one-hot grant (transfer on valid & ready)
//   req_we     in   [NREQ]     1 = write, 0 = read
//   req_addr   in   [NREQ*AW]  packed addresses, requester i at [i*AW +: AW]
//   req_wdata  in   [NREQ*DW]  packed write data, requester i at [i*DW +: DW]
//   rsp_valid  out  [NREQ]     one-hot read-response strobe
//   rsp_data   out  [DW]       read data, valid while rsp_valid != 0
//   busy       out             clear sweep in progress
//   mem_a/mem_d/mem_we/mem_wem/mem_ce  out  BRAM port controls
//   mem_q      in   [DW]       BRAM port read data
// -----------------------------------------------------------------------------
module bram_rr_port_arbiter #(
    parameter int NREQ = 4,
    parameter int AW   = 13,
    parameter int DW   = 2
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [NREQ-1:0]      req_we,
    input  logic [NREQ*AW-1:0]   req_addr,
    input  logic [NREQ*DW-1:0]   req_wdata,
    output logic [NREQ-1:0]      rsp_valid,
    output logic [DW-1:0]        rsp_data,
    output logic                 busy,
    output logic [AW-1:0]        mem_a,
    output logic [DW-1:0]        mem_d,
    output logic                 mem_we,
    output logic [DW-1:0]        mem_wem,
    output logic                 mem_ce,
    input  logic [DW-1:0]        mem_q
);

    localparam int PW = $clog2(NREQ);

    // (base + off) mod NREQ, for base < NREQ and off < NREQ.
    function automatic logic [PW-1:0] wrap_idx(input logic [PW-1:0] base, input int off);
        int s;
        s = int'(base) + off;
        if (s >= NREQ) s = s - NREQ;
        return PW'(s);
    endfunction

    logic                clearing;
    logic [AW-1:0]       sweep_addr;
    logic [PW-1:0]       ptr_q;
    logic [PW-1:0]       gidx;
    logic                found;
    logic [NREQ-1:0]     grant;
    logic                xfer;
    logic                rd_xfer;
    logic [NREQ-1:0]     rsp_sel_p1;

`ifdef BRAM_ARB_CLEAR_ON_RESET_EN
    typedef enum logic {ST_CLEAR, ST_RUN} state_t;

    state_t        state_q, state_d;
    logic [AW-1:0] clr_addr_q;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= ST_CLEAR;
            clr_addr_q <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == ST_CLEAR) clr_addr_q <= clr_addr_q + 1'b1;
        end
    end

    // Leave CLEAR once the last address has been written this cycle.
    always_comb begin
        state_d = state_q;
        if (state_q == ST_CLEAR && (&clr_addr_q)) state_d = ST_RUN;
    end

    assign clearing   = (state_q == ST_CLEAR);
    assign sweep_addr = clr_addr_q;
`else
    assign clearing   = 1'b0;
    assign sweep_addr = '0;
`endif

    // Round-robin scan starting at ptr_q; first valid requester wins.
    always_comb begin
        logic [PW-1:0] idx;
        idx   = '0;
        gidx  = '0;
        found = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            idx = wrap_idx(ptr_q, k);
            if (!found && req_valid[idx]) begin
                found = 1'b1;
                gidx  = idx;
            end
        end
        grant = found ? (NREQ'(1) << gidx) : '0;
    end

    assign xfer    = !clearing && found;
    assign rd_xfer = xfer && !req_we[gidx];

    always_comb begin
        req_ready = '0;
        mem_ce    = 1'b0;
        mem_a     = '0;
        mem_d     = '0;
        mem_we    = 1'b0;
        mem_wem   = '0;
        if (clearing) begin
            mem_ce  = 1'b1;
            mem_we  = 1'b1;
            mem_wem = '1;
            mem_a   = sweep_addr;
        end else if (found) begin
            req_ready = grant;
            mem_ce    = 1'b1;
            mem_a     = req_addr[gidx*AW +: AW];
            mem_d     = req_wdata[gidx*DW +: DW];
            mem_we    = req_we[gidx];
            mem_wem   = req_we[gidx] ? '1 : '0;
        end
    end

    // Stage p1: remember which requester owns the read data the BRAM returns
    // on the next cycle; the pointer moves past the winner.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            ptr_q      <= '0;
            rsp_sel_p1 <= '0;
        end else begin
            if (xfer) ptr_q <= wrap_idx(gidx, 1);
            rsp_sel_p1 <= rd_xfer ? grant : '0;
        end
    end

    assign rsp_valid = rsp_sel_p1;
    assign rsp_data  = mem_q;
    assign busy      = clearing;

endmodule

// File: tb/tb_bram_rr_port_arbiter.sv
module tb_bram_rr_port_arbiter;

    localparam int NREQ = 4;
    localparam int AW   = 13;
    localparam int DW   = 2;

`ifdef BRAM_ARB_CLEAR_ON_RESET_EN
    localparam logic       CLR_EN    = 1'b1;
    localparam logic [1:0] INITV     = 2'b00;  // sweep zeroes the array
`else
    localparam logic       CLR_EN    = 1'b0;
    localparam logic [1:0] INITV     = 2'b01;  // BRAM model power-up value
`endif

    logic                 clk = 1'b0;
    logic                 rstn;
    logic [NREQ-1:0]      req_valid;
    logic [NREQ-1:0]      req_ready;
    logic [NREQ-1:0]      req_we;
    logic [NREQ*AW-1:0]   req_addr;
    logic [NREQ*DW-1:0]   req_wdata;
    logic [NREQ-1:0]      rsp_valid;
    logic [DW-1:0]        rsp_data;
    logic                 busy;
    logic [AW-1:0]        mem_a;
    logic [DW-1:0]        mem_d;
    logic                 mem_we;
    logic [DW-1:0]        mem_wem;
    logic                 mem_ce;
    logic [DW-1:0]        mem_q;

    bram_rr_port_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW)) dut (
        .clk(clk), .rstn(rstn),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .busy(busy),
        .mem_a(mem_a), .mem_d(mem_d), .mem_we(mem_we), .mem_wem(mem_wem),
        .mem_ce(mem_ce), .mem_q(mem_q)
    );

    always #5 clk = ~clk;

    // Behavioural BRAM port: registered read, masked write.
    logic [DW-1:0] bmem [0:(1<<AW)-1];
    initial begin
        for (int a = 0; a < (1 << AW); a++) bmem[a] = 2'b01;
        mem_q = '0;
    end
    always @(posedge clk) begin
        if (mem_ce) begin
            if (mem_we) bmem[mem_a] <= (bmem[mem_a] & ~mem_wem) | (mem_d & mem_wem);
            else        mem_q <= bmem[mem_a];
        end
    end

    int errors = 0;
    int checks = 0;
    int cyc    = 0;
    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        int              due;
        logic [NREQ-1:0] v;
        logic [DW-1:0]   d;
    } exp_t;
    exp_t sbq[$];

    // Monitor: every response must be due this cycle; due entries must appear.
    always @(negedge clk) begin
        if (sbq.size() != 0 && sbq[0].due == cyc) begin
            exp_t e;
            e = sbq.pop_front();
            chk("rsp_valid", 32'(rsp_valid), 32'(e.v));
            chk("rsp_data",  32'(rsp_data),  32'(e.d));
        end else if (rsp_valid != '0) begin
            chk("unexpected_rsp", 32'(rsp_valid), 32'h0);
        end
    end

    task automatic set_req(input int i, input logic v, input logic we,
                           input logic [AW-1:0] a, input logic [DW-1:0] d);
        req_valid[i]         = v;
        req_we[i]            = we;
        req_addr[i*AW +: AW] = a;
        req_wdata[i*DW +: DW]= d;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Check the grant at the negedge; for a read, queue the response for next cycle.
    task automatic expect_grant(input string name, input logic [NREQ-1:0] exp,
                                input logic is_read, input logic [DW-1:0] d);
        exp_t e;
        @(negedge clk);
        chk(name, 32'(req_ready), 32'(exp));
        if (is_read) begin
            e.due = cyc + 1;
            e.v   = exp;
            e.d   = d;
            sbq.push_back(e);
        end
    endtask

    initial begin
        logic bad;
        rstn      = 1'b0;
        req_valid = '0;
        req_we    = '0;
        req_addr  = '0;
        req_wdata = '0;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'h0);
        chk("rst_busy",      32'(busy),      32'(CLR_EN));
        chk("rst_mem_ce",    32'(mem_ce),    32'(CLR_EN));

`ifdef BRAM_ARB_CLEAR_ON_RESET_EN
        // Requesters hold writes of 0 during the sweep; none may be granted.
        for (int i = 0; i < NREQ; i++) set_req(i, 1'b1, 1'b1, 13'h0FFF, 2'b00);
        @(negedge clk);
        chk("rst_ready_clear", 32'(req_ready), 32'h0);
        next_cycle();
        rstn = 1'b1;
        bad = 1'b0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (mem_a != AW'(k) || !busy || !mem_we || mem_d != 2'b00 ||
                mem_wem != 2'b11 || !mem_ce || req_ready != '0) bad = 1'b1;
        end
        chk("sweep_prefix", 32'(bad), 32'h0);
        @(negedge clk);
        chk("sweep_at_100", 32'(mem_a), 32'd100);
        #1 rstn = 1'b0;
        #1 chk("sweep_reset_addr", 32'(mem_a), 32'h0);
        next_cycle();
        rstn = 1'b1;
        bad = 1'b0;
        for (int k = 0; k < (1 << AW); k++) begin
            @(negedge clk);
            if (mem_a != AW'(k) || !busy || !mem_we || mem_d != 2'b00 ||
                mem_wem != 2'b11 || !mem_ce || req_ready != '0) bad = 1'b1;
        end
        chk("sweep_full", 32'(bad), 32'h0);
        @(negedge clk);
        chk("sweep_done_busy", 32'(busy), 32'h0);
        chk("first_grant", 32'(req_ready), 32'h1);
        req_valid = '0;  // withdraw before the edge: no transfer, ptr stays 0
        next_cycle();
`else
        next_cycle();
        rstn = 1'b1;
        set_req(2, 1'b1, 1'b0, 13'h1ABC, 2'b00);
        @(negedge clk);
        chk("busy_low", 32'(busy), 32'h0);
        chk("first_grant", 32'(req_ready), 32'h4);
        req_valid = '0;  // withdraw before the edge: no transfer, ptr stays 0
        next_cycle();
`endif

        // All four held: grants 0,1,2,3,0 (writes of i to 0x10+i)
        for (int i = 0; i < NREQ; i++) set_req(i, 1'b1, 1'b1, AW'(16 + i), DW'(i));
        for (int g = 0; g < 5; g++) begin
            @(negedge clk);
            chk($sformatf("rr_grant_%0d", g), 32'(req_ready), 32'(1 << (g % 4)));
            chk($sformatf("rr_addr_%0d", g), 32'({mem_we, mem_wem, mem_a}),
                32'({1'b1, 2'b11, AW'(16 + (g % 4))}));
            next_cycle();
        end
        req_valid = '0;  // ptr = 1

        // Only requester 3 valid with ptr=1: write 2 to 0x0007, no response
        set_req(3, 1'b1, 1'b1, 13'h0007, 2'b10);
        expect_grant("only3_grant", 4'b1000, 1'b0, 2'b00);
        chk("only3_mem", 32'({mem_ce, mem_d, mem_a}), 32'({1'b1, 2'b10, 13'h0007}));
        next_cycle();
        req_valid = '0;  // ptr = 0

        // ptr back at 0: requester 0 beats 3; back-to-back reads
        set_req(0, 1'b1, 1'b0, 13'h1ABC, 2'b00);
        set_req(3, 1'b1, 1'b0, 13'h0013, 2'b00);
        expect_grant("ptr0_grant", 4'b0001, 1'b1, INITV);
        next_cycle();
        req_valid[0] = 1'b0;
        expect_grant("b2b_grant3", 4'b1000, 1'b1, 2'b11);
        next_cycle();
        req_valid = '0;  // ptr = 0

        // Requester 2 writes 3 to 0x0005, requester 1 reads it next cycle
        set_req(2, 1'b1, 1'b1, 13'h0005, 2'b11);
        expect_grant("wr5_grant", 4'b0100, 1'b0, 2'b00);
        next_cycle();
        req_valid = '0;  // ptr = 3
        set_req(1, 1'b1, 1'b0, 13'h0005, 2'b00);
        expect_grant("rd5_grant", 4'b0010, 1'b1, 2'b11);
        next_cycle();
        set_req(1, 1'b1, 1'b0, 13'h0011, 2'b00);  // ptr = 2
        expect_grant("rd11_grant", 4'b0010, 1'b1, 2'b01);
        next_cycle();
        req_valid = '0;  // ptr = 2

        // Same-address read (0) and write (1): grant order decides
        set_req(0, 1'b1, 1'b0, 13'h0020, 2'b00);
        set_req(1, 1'b1, 1'b1, 13'h0020, 2'b10);
        expect_grant("race_rd_first", 4'b0001, 1'b1, INITV);
        next_cycle();
        req_valid[0] = 1'b0;
        expect_grant("race_wr", 4'b0010, 1'b0, 2'b00);
        next_cycle();
        req_valid = '0;
        set_req(0, 1'b1, 1'b0, 13'h0020, 2'b00);
        expect_grant("race_rd_after", 4'b0001, 1'b1, 2'b10);
        next_cycle();
        req_valid = '0;

        // Idle
        repeat (3) next_cycle();
        @(negedge clk);
        chk("idle_ce", 32'(mem_ce), 32'h0);
        chk("idle_ready", 32'(req_ready), 32'h0);
        chk("sb_drained", 32'(sbq.size()), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
